// File: rtl/gemm_group_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : gemm_group_scheduler
// Purpose  : Assembles host command words into groups, queues them, and
//            launches each group into the GEMM dispatcher, tracking completion.
// Revision : 1.0 - initial release
// ============================================================================
module gemm_group_scheduler #(
  parameter int FIFO_WIDTH  = 32,
  parameter int FIFO_NUM    = 5,
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [FIFO_WIDTH-1:0]                cmd_data,
  input  logic                                 flush,
  input  logic                                 gemm_idle,
  input  logic                                 op_done,
  output logic                                 group_push,
  output logic [FIFO_NUM-1:0][FIFO_WIDTH-1:0]  group_data,
  output logic [$clog2(QUEUE_DEPTH):0]         queue_level,
  output logic                                 busy,
  output logic [CNT_WIDTH-1:0]                 groups_done,
  output logic                                 irq,
  output logic                                 spurious_done,
  input  logic                                 irq_clear
);

  localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;
  localparam int c_WC_W  = $clog2(FIFO_NUM);
  localparam logic [c_WC_W-1:0]  c_LAST  = c_WC_W'(FIFO_NUM - 1);
  localparam logic [c_LVL_W-1:0] c_DEPTH = c_LVL_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PUSH      = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t                                  r_state;
  state_t                                  w_state_nxt;
  logic [c_WC_W-1:0]                       r_word_cnt;
  logic [c_PTR_W-1:0]                      r_head;
  logic [c_PTR_W-1:0]                      r_tail;
  logic [c_LVL_W-1:0]                      r_level;
  logic [FIFO_NUM-2:0][FIFO_WIDTH-1:0]     r_asm;
  logic [FIFO_NUM-1:0][FIFO_WIDTH-1:0]     r_mem [QUEUE_DEPTH];
  logic [FIFO_NUM-1:0][FIFO_WIDTH-1:0]     w_group;
  logic                                    w_full;
  logic                                    w_empty;
  logic                                    w_accept;
  logic                                    w_commit;
  logic                                    w_pop;
  logic                                    w_done_ok;

  assign w_full    = (r_level == c_DEPTH);
  assign w_empty   = (r_level == '0);
  // Only the group-closing word needs a free queue slot; flush refuses all words.
  assign cmd_ready = ~flush & (~w_full | (r_word_cnt != c_LAST));
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_commit  = w_accept & (r_word_cnt == c_LAST);
  assign w_group   = {cmd_data, r_asm};
  assign w_done_ok = (r_state == S_WAIT_DONE) & op_done;

  assign group_push  = (r_state == S_PUSH);
  assign queue_level = r_level;
  assign busy        = (r_state != S_IDLE) | ~w_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (~w_empty && gemm_idle && ~flush) begin
          w_pop       = 1'b1;
          w_state_nxt = S_PUSH;
        end
      end
      S_PUSH:      w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (op_done) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word_cnt <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_level    <= '0;
    end else if (flush) begin
      r_word_cnt <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_level    <= '0;
    end else begin
      if (w_accept) begin
        r_word_cnt <= (r_word_cnt == c_LAST) ? '0 : r_word_cnt + c_WC_W'(1);
      end
      if (w_commit) r_tail <= r_tail + c_PTR_W'(1);
      if (w_pop)    r_head <= r_head + c_PTR_W'(1);
      case ({w_commit, w_pop})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by pointers and level.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_NUM - 1; i++) begin
      if (w_accept && (r_word_cnt == c_WC_W'(i))) r_asm[i] <= cmd_data;
    end
    if (w_commit) r_mem[r_tail] <= w_group;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      group_data    <= '0;
      groups_done   <= '0;
      irq           <= 1'b0;
      spurious_done <= 1'b0;
    end else begin
      if (w_pop)     group_data  <= r_mem[r_head];
      if (w_done_ok) groups_done <= groups_done + CNT_WIDTH'(1);
      if (w_done_ok && w_empty && ~w_commit) irq <= 1'b1;
      else if (irq_clear)                    irq <= 1'b0;
      if (op_done && (r_state != S_WAIT_DONE)) spurious_done <= 1'b1;
      else if (irq_clear)                      spurious_done <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gemm_group_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_gemm_group_scheduler
// Purpose  : Directed scoreboard bench for gemm_group_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gemm_group_scheduler;

  typedef logic [4:0][31:0] grp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_data;
  logic        flush;
  logic        gemm_idle;
  logic        op_done;
  logic        group_push;
  grp_t        group_data;
  logic [2:0]  queue_level;
  logic        busy;
  logic [7:0]  groups_done;
  logic        irq;
  logic        spurious_done;
  logic        irq_clear;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_push = 0;
  int          push_mark;
  logic [7:0]  exp_done = 8'd0;
  grp_t        sb [$];
  grp_t        mon_exp;
  grp_t        g;

  gemm_group_scheduler #(
    .FIFO_WIDTH(32), .FIFO_NUM(5), .QUEUE_DEPTH(4), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .flush(flush), .gemm_idle(gemm_idle), .op_done(op_done),
    .group_push(group_push), .group_data(group_data), .queue_level(queue_level),
    .busy(busy), .groups_done(groups_done), .irq(irq),
    .spurious_done(spurious_done), .irq_clear(irq_clear)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every launch must match the oldest outstanding expected group.
  always @(negedge clk) begin
    if (reset === 1'b1 && group_push === 1'b1) begin
      n_push++;
      n_chk++;
      if (sb.size() == 0) begin
        $display("FAIL group_data: unexpected launch %h, scoreboard empty", group_data);
      end else begin
        mon_exp = sb.pop_front();
        if (group_data === mon_exp) n_pass++;
        else $display("FAIL group_data: got %h expected %h", group_data, mon_exp);
      end
    end
  end

  function automatic grp_t mk(input logic [31:0] base);
    grp_t r;
    for (int i = 0; i < 5; i++) r[i] = base | 32'(i);
    return r;
  endfunction

  task automatic send_word(input logic [31:0] d);
    int t = 0;
    bit rdy = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_data  = d;
    do begin
      @(negedge clk);
      rdy = cmd_ready;
      @(posedge clk); #1;
      t++;
    end while (!rdy && t < 100);
    if (!rdy) chk("cmd_accept_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic send_group(input grp_t gg, input bit expect_launch);
    if (expect_launch) sb.push_back(gg);
    for (int i = 0; i < 5; i++) send_word(gg[i]);
  endtask

  task automatic wait_push();
    int t = 0;
    @(negedge clk);
    while (group_push !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (group_push !== 1'b1) chk("launch_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 op_done = 1'b1;
    @(posedge clk); #1 op_done = 1'b0;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 irq_clear = 1'b1;
    @(posedge clk); #1 irq_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_data = '0; flush = 1'b0;
    gemm_idle = 1'b1; op_done = 1'b0; irq_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_group_push", group_push, 0);
    chk("rst_group_data", 32'(group_data != '0), 0);
    chk("rst_queue_level", queue_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_groups_done", groups_done, 0);
    chk("rst_irq", irq, 0);
    chk("rst_spurious", spurious_done, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    // Single group: launch two cycles after the closing word
    g[0] = 32'h21; g[1] = 32'h100; g[2] = 32'h200; g[3] = 32'h300; g[4] = 32'h400;
    send_group(g, 1'b1);
    @(negedge clk);
    chk("t1_push_n1", group_push, 0);
    chk("t1_level_n1", queue_level, 1);
    @(negedge clk);
    chk("t1_push_n2", group_push, 1);
    chk("t1_level_n2", queue_level, 0);
    chk("t1_busy", busy, 1);
    pulse_done(); exp_done++;
    @(negedge clk);
    chk("t1_groups_done", groups_done, exp_done);
    chk("t1_irq", irq, 1);
    chk("t1_busy_after", busy, 0);
    pulse_clear();
    @(negedge clk);
    chk("t1_irq_cleared", irq, 0);

    // Full queue stalls only the closing word
    @(posedge clk); #1 gemm_idle = 1'b0;
    for (int k = 0; k < 4; k++) send_group(mk(32'h1000 * (k + 1)), 1'b1);
    @(negedge clk);
    chk("t2_level_full", queue_level, 4);
    g = mk(32'h5000);
    sb.push_back(g);
    for (int i = 0; i < 4; i++) send_word(g[i]);
    @(posedge clk); #1 cmd_valid = 1'b1; cmd_data = g[4];
    @(negedge clk);
    chk("t2_ready_stall", cmd_ready, 0);
    gemm_idle = 1'b1;
    @(negedge clk);
    chk("t2_ready_after_pop", cmd_ready, 1);
    chk("t2_push", group_push, 1);
    chk("t2_level_pop", queue_level, 3);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("t2_level_refill", queue_level, 4);
    pulse_done(); exp_done++;
    for (int k = 0; k < 4; k++) begin
      wait_push(); pulse_done(); exp_done++;
    end
    @(negedge clk);
    chk("t2_groups_done", groups_done, exp_done);
    chk("t2_irq", irq, 1);
    pulse_clear();

    // Commit and pop in the same cycle; order across six groups
    send_group(mk(32'hA000), 1'b1);
    wait_push();
    send_group(mk(32'hB100), 1'b1);
    g = mk(32'hC200);
    sb.push_back(g);
    for (int i = 0; i < 4; i++) send_word(g[i]);
    @(posedge clk); #1 op_done = 1'b1; exp_done++;
    @(posedge clk); #1 op_done = 1'b0; cmd_valid = 1'b1; cmd_data = g[4];
    @(negedge clk);
    chk("t3_level_before", queue_level, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("t3_level_commit_pop", queue_level, 1);
    chk("t3_push", group_push, 1);
    send_group(mk(32'hD300), 1'b1);
    send_group(mk(32'hE400), 1'b1);
    send_group(mk(32'hF500), 1'b1);
    pulse_done(); exp_done++;
    for (int k = 0; k < 4; k++) begin
      wait_push(); pulse_done(); exp_done++;
    end
    @(negedge clk);
    chk("t3_groups_done", groups_done, exp_done);
    chk("t3_irq", irq, 1);
    chk("t3_level_empty", queue_level, 0);
    pulse_clear();

    // Spurious completion in IDLE
    @(posedge clk); #1 op_done = 1'b1;
    @(posedge clk); #1 op_done = 1'b0;
    @(negedge clk);
    chk("t4_spurious", spurious_done, 1);
    chk("t4_groups_done", groups_done, exp_done);
    chk("t4_irq_quiet", irq, 0);
    pulse_clear();
    @(negedge clk);
    chk("t4_spurious_clr", spurious_done, 0);
    chk("t4_irq_clr", irq, 0);

    // Flush with a group in flight, three queued and a partial group
    send_group(mk(32'h7000), 1'b1);
    wait_push();
    send_group(mk(32'h7100), 1'b0);
    send_group(mk(32'h7200), 1'b0);
    send_group(mk(32'h7300), 1'b0);
    send_word(32'h7400);
    send_word(32'h7401);
    @(negedge clk);
    chk("t5_level_pre", queue_level, 3);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("t5_ready_flush", cmd_ready, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("t5_level_flushed", queue_level, 0);
    chk("t5_busy_inflight", busy, 1);
    push_mark = n_push;
    pulse_done(); exp_done++;
    @(negedge clk);
    chk("t5_groups_done", groups_done, exp_done);
    chk("t5_irq", irq, 1);
    repeat (10) @(negedge clk);
    chk("t5_no_push", n_push, push_mark);
    pulse_clear();
    send_group(mk(32'h7800), 1'b1);
    wait_push(); pulse_done(); exp_done++;

    // Counter wrap, then reset in WAIT_DONE
    while (exp_done != 8'd255) begin
      send_group(mk({16'h0, exp_done, 8'h0}), 1'b1);
      wait_push(); pulse_done(); exp_done++;
    end
    @(negedge clk);
    chk("t6_groups_done_255", groups_done, 255);
    send_group(mk(32'h9900), 1'b1);
    wait_push(); pulse_done(); exp_done++;
    @(negedge clk);
    chk("t6_groups_done_wrap", groups_done, 0);
    send_group(mk(32'h9A00), 1'b1);
    wait_push();
    @(posedge clk); #1 reset = 1'b0;
    #1;
    chk("t6_rst_push", group_push, 0);
    chk("t6_rst_data", 32'(group_data != '0), 0);
    chk("t6_rst_level", queue_level, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_groups_done", groups_done, 0);
    chk("t6_rst_irq", irq, 0);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
